// File: rtl/seq_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seq_mult_ctrl
// Purpose  : Shift-add unsigned multiplier that reuses one WIDTH-bit adder
//            over WIDTH cycles, with start/busy/done handshake and abort.
// Revision : 1.0 - initial release
// ============================================================================
module seq_mult_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] C_LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]     r_acc_hi;
  logic [WIDTH-1:0]     r_acc_lo;
  logic [CW-1:0]        r_count;
  logic                 r_busy;
  logic                 r_done;
  logic [2*WIDTH-1:0]   r_product;

  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_next_acc;

  // The adder keeps its carry bit; the right shift folds it into acc_hi.
  assign w_sum      = r_acc_lo[0] ? ({1'b0, r_acc_hi} + {1'b0, r_mcand})
                                  : {1'b0, r_acc_hi};
  assign w_next_acc = {w_sum, r_acc_lo[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_mcand   <= '0;
      r_acc_hi  <= '0;
      r_acc_lo  <= '0;
      r_count   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state  <= S_CALC;
            r_busy   <= 1'b1;
            r_mcand  <= A;
            r_acc_hi <= '0;
            r_acc_lo <= B;
            r_count  <= '0;
          end
        end
        S_CALC: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            {r_acc_hi, r_acc_lo} <= w_next_acc;
            r_count              <= r_count + 1'b1;
            if (r_count == C_LAST_CNT) begin
              r_state   <= S_DONE;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
              r_product <= w_next_acc;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;

endmodule
`default_nettype wire

// File: tb/tb_seq_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_mult_ctrl
// Purpose  : Self-checking bench for seq_mult_ctrl (WIDTH=4) with a queue of
//            expected products consumed on each done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_mult_ctrl;

  localparam int WIDTH = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               abort;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  int                 n_tests = 0;
  int                 n_fail  = 0;
  logic [2*WIDTH-1:0] exp_q[$];

  seq_mult_ctrl #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .abort   (abort),
    .A       (A),
    .B       (B),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  // Drives a one-cycle start and returns at the negedge after the accept edge.
  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input bit with_abort, input bit expect_result);
    @(negedge clk);
    A = a; B = b; start = 1'b1; abort = with_abort;
    if (expect_result) exp_q.push_back((2*WIDTH)'(a) * (2*WIDTH)'(b));
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    A = ~a; B = ~b;
  endtask

  // Waits (bounded) for done, checking latency, busy span and the product.
  task automatic finish_op(input string tag, input int exp_lat, input int exp_busy);
    int cyc = 0;
    int busy_cnt = 0;
    logic [2*WIDTH-1:0] exp;
    while (done !== 1'b1 && cyc < 20) begin
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
    n_tests++;
    if (cyc != exp_lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d cycles, expected %0d", tag, cyc, exp_lat);
    end
    n_tests++;
    if (busy_cnt != exp_busy || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s busy: got %0d busy cycles (busy@done=%b), expected %0d (0)",
               tag, busy_cnt, busy, exp_busy);
    end
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s scoreboard: got done with product %0d, expected no result", tag, product);
    end else begin
      exp = exp_q.pop_front();
      if (product !== exp) begin
        n_fail++;
        $display("FAIL %s product: got %0d, expected %0d", tag, product, exp);
      end
    end
  endtask

  // Checks that nothing happens for n cycles: no busy, no done, product held.
  task automatic check_quiet(input string tag, input int n, input logic [2*WIDTH-1:0] exp_p);
    bit bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0 || product !== exp_p) begin
        if (!bad) $display("FAIL %s quiet: got busy=%b done=%b product=%0d, expected 0 0 %0d",
                           tag, busy, done, product, exp_p);
        bad = 1;
      end
    end
    n_tests++;
    if (bad) n_fail++;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; A = '0; B = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_tests++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
        n_fail++;
        $display("FAIL reset cycle %0d: got busy=%b done=%b product=%0d, expected 0 0 0",
                 i, busy, done, product);
      end
    end
  endtask

  task automatic test_basic();
    start_op(4'd13, 4'd11, 1'b0, 1'b1);
    finish_op("basic_13x11", WIDTH, WIDTH);
    n_tests++;
    if (product !== 8'h8F) begin
      n_fail++;
      $display("FAIL basic_const: got %0h, expected 8f", product);
    end
    check_quiet("basic_hold", 5, 8'h8F);
  endtask

  task automatic test_max_zero();
    start_op(4'd15, 4'd15, 1'b0, 1'b1);
    finish_op("max_15x15", WIDTH, WIDTH);
    start_op(4'd0, 4'd9, 1'b0, 1'b1);
    finish_op("zero_0x9", WIDTH, WIDTH);
    start_op(4'd15, 4'd1, 1'b0, 1'b1);
    finish_op("one_15x1", WIDTH, WIDTH);
  endtask

  task automatic test_start_while_busy();
    start_op(4'd3, 4'd5, 1'b0, 1'b1);
    @(negedge clk);
    A = 4'd7; B = 4'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_op("busy_start", WIDTH - 2, WIDTH - 2);
    check_quiet("busy_start_no_second", 10, 8'd15);
  endtask

  task automatic test_abort();
    start_op(4'd13, 4'd11, 1'b0, 1'b1);
    finish_op("abort_pre", WIDTH, WIDTH);
    start_op(4'd9, 4'd9, 1'b0, 1'b0);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_busy_drop: got busy=%b, expected 0", busy);
    end
    check_quiet("abort_hold", 10, 8'd143);
    start_op(4'd2, 4'd6, 1'b0, 1'b1);
    finish_op("abort_next_2x6", WIDTH, WIDTH);
    // start and abort together in IDLE: the start must still be accepted
    start_op(4'd5, 4'd3, 1'b1, 1'b1);
    finish_op("start_abort_idle", WIDTH, WIDTH);
  endtask

  task automatic test_async_reset();
    start_op(4'd9, 4'd7, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got busy=%b done=%b product=%0d, expected 0 0 0",
               busy, done, product);
    end
    @(negedge clk);
    rst = 1'b0;
    check_quiet("async_reset_no_done", 10, '0);
  endtask

  task automatic test_back_to_back();
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        start_op(4'(a), 4'(b), 1'b0, 1'b1);
        finish_op($sformatf("sweep_%0dx%0d", a, b), WIDTH, WIDTH);
      end
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max_zero();
    test_start_while_busy();
    test_abort();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
